keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter FCOUNT, default 100_000, clk cycles per scan tick (1 kHz at 100 MHz).
REQ-002 Parameter DEB_SCANS, default 4, consecutive ticks needed to accept a press or a release.
REQ-003 Parameter REPEAT_TICKS, default 500, ticks between auto-repeat pulses (used only with REQ-030).
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key_col  input  4  column lines, active-low, externally pulled up.
REQ-007 key_row  output  4  row drive, active-low, exactly one row low.
REQ-008 key_code  output  4  code of the accepted key, 0x0-0xF.
REQ-009 key_valid  output  1  one-clk pulse per accepted press.
REQ-010 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-011 The tick SHALL be a one-clk pulse every FCOUNT clk cycles from a counter that wraps at FCOUNT-1.
REQ-012 The row index SHALL advance 0->1->2->3->0 on each tick in SCAN; key_row = 1110, 1101, 1011, 0111 for rows 0-3.
REQ-013 Columns SHALL be sampled on the tick, before the row advances, through a 2-flop synchronizer.
REQ-014 FSM states SHALL be SCAN, DEB_PRESS, PRESSED and DEB_REL.
REQ-015 SCAN -> DEB_PRESS when exactly one column is low at a sample; the row freezes and that column pattern is latched.
REQ-016 A sample with more than one column low SHALL count as no key (ghost rejection).
REQ-017 DEB_PRESS: the debounce counter increments on each tick whose sample matches the latched pattern.
REQ-018 DEB_PRESS: any mismatching sample SHALL return the FSM to SCAN and resume scanning from the next row.
REQ-019 DEB_PRESS -> PRESSED when the counter reaches DEB_SCANS.
REQ-020 On entry to PRESSED: key_code = row*4 + col_index (col_index = position of the low bit); key_valid pulses high for exactly one clk in that cycle; key_held = 1.
REQ-021 PRESSED -> DEB_REL on the first sample with all columns high.
REQ-022 DEB_REL -> SCAN after DEB_SCANS consecutive all-high samples; key_held = 0 on that transition.
REQ-023 DEB_REL: any low column SHALL return the FSM to PRESSED without a new key_valid.
REQ-024 key_code SHALL hold its last value until the next accepted press.
REQ-025 Latency from a stable press to key_valid SHALL be at most (4 + DEB_SCANS) ticks plus 3 clk.
REQ-026 A second key pressed while in PRESSED SHALL be ignored until the release sequence completes.

Reset
REQ-027 While rst = 0: FSM = SCAN, row index = 0, key_row = 1110, key_code = 0, key_valid = 0, key_held = 0, all counters and synchronizers cleared.
REQ-028 Reset asserted mid-press SHALL abort the press with no key_valid; after release of reset, scanning restarts at row 0.

Configuration
REQ-029 Macro KEYPAD_AUTOREPEAT_EN controls auto-repeat.
REQ-030 Defined: while in PRESSED, key_valid re-pulses every REPEAT_TICKS ticks with an unchanged key_code. Undefined: exactly one pulse per press, and the repeat counter is not synthesized.

Structure
REQ-031 A shared package keypad_pkg SHALL hold the FSM state encoding, the 4 row drive patterns, and the FCOUNT/DEB_SCANS/REPEAT_TICKS defaults.
REQ-032 One sub-module, keypad_tick_gen (parameter FCOUNT, ports clk/rst/o_tick), SHALL produce the tick.

Verification (sim with FCOUNT=4, DEB_SCANS=4)
REQ-033 Reset -> key_row = 1110, key_valid = 0, key_code = 0; after release, key_row steps 1101, 1011, 0111 every 4 clk.
REQ-034 Hold row 2 / col 1 low (key_col = 1101 while key_row = 1011) -> single key_valid pulse with key_code = 0x9, key_held = 1.
REQ-035 Release, then 4 all-high samples -> key_held = 0 and scanning resumes; 2-sample release glitch -> no second key_valid.
REQ-036 Bounce on row 0 / col 3 (low, high, low) before a stable press -> no key_valid until 4 stable samples, then key_code = 0x3.
REQ-037 key_col = 1100 on row 1 -> no key_valid and scanning continues; reset asserted during DEB_PRESS -> no pulse and key_row = 1110.
REQ-038 With KEYPAD_AUTOREPEAT_EN and REPEAT_TICKS=8, holding key 0xF -> key_valid every 32 clk after the first pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner: FSM encoding,
// row drive patterns and parameter defaults.
package keypad_pkg;

  localparam int unsigned FCOUNT_DEFAULT       = 100_000;
  localparam int unsigned DEB_SCANS_DEFAULT    = 4;
  localparam int unsigned REPEAT_TICKS_DEFAULT = 500;

  localparam logic [1:0] ST_SCAN      = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_DEB_REL   = 2'd3;

  // Element n drives row n low; element 0 is the rightmost nibble.
  localparam logic [3:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // True when exactly one active-low column is asserted.
  function automatic logic single_low(input logic [3:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) || (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

  // Position of the single low column; only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle. The scanner uses the master modport; the keypad
// (or a bench model of it) uses the slave modport.
interface keypad_scanner_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  key_col,
    output key_row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output key_col,
    input  key_row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_tick_gen.sv
// Scan tick generator: one-clk pulse every FCOUNT clocks from a wrapping counter.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned FCOUNT = FCOUNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FCOUNT - 1);

  logic [CW-1:0] cnt_q;

  // Free-running counter wrapping at FCOUNT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and ghost rejection.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned FCOUNT       = FCOUNT_DEFAULT,
  parameter int unsigned DEB_SCANS    = DEB_SCANS_DEFAULT,
  parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  keypad_scanner_if.master  kp
);

  localparam int unsigned DW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_SCANS - 1);

  // FCOUNT < 3 would sample columns before the synchronizer sees the new row.
  if (FCOUNT < 3 || DEB_SCANS == 0 || REPEAT_TICKS == 0) begin : g_param_check
    $error("keypad_scanner: FCOUNT must be >= 3, DEB_SCANS and REPEAT_TICKS >= 1");
  end

  logic          tick;
  logic [3:0]    col_s1_q, col_s2_q;
  logic [1:0]    state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  keypad_tick_gen #(
    .FCOUNT (FCOUNT)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // Two-flop synchronizer for the asynchronous column lines; idle is all-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= kp.key_col;
      col_s2_q <= col_s1_q;
    end
  end

  // Scan/debounce FSM next-state; everything moves only on a tick sample.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pat_d   = pat_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          // Multiple low columns fall through as "no key".
          if (single_low(col_s2_q)) begin
            state_d = ST_DEB_PRESS;
            pat_d   = col_s2_q;
            deb_d   = '0;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        ST_DEB_PRESS: begin
          if (col_s2_q == pat_q) begin
            if (deb_q == DEB_LAST) begin
              state_d = ST_PRESSED;
              code_d  = {row_q, low_index(pat_q)};
              valid_d = 1'b1;
              held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        ST_PRESSED: begin
          // Other keys pressed meanwhile are ignored until full release.
          if (col_s2_q == 4'hF) begin
            state_d = ST_DEB_REL;
            deb_d   = '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_q == REP_LAST) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
        ST_DEB_REL: begin
          if (col_s2_q == 4'hF) begin
            if (deb_q == DEB_LAST) begin
              state_d = ST_SCAN;
              held_d  = 1'b0;
              row_d   = row_q + 2'd1;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SCAN;
      row_q   <= 2'd0;
      pat_q   <= 4'hF;
      deb_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign kp.key_row   = ROW_DRIVE[row_q];
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model and a
// queue of expected key codes popped on each key_valid pulse.
module tb_keypad_scanner;

  localparam int unsigned FC = 4;
  localparam int unsigned DS = 4;
  localparam int unsigned RT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .FCOUNT       (FC),
    .DEB_SCANS    (DS),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Keypad model: the pressed key pulls its column low only while its row is driven.
  logic       press_en  = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [3:0] press_col = 4'hF;
  logic       ghost     = 1'b0;
  logic [3:0] row_sel;
  assign row_sel = ~(4'b0001 << press_row);
  assign kp.key_col = ghost ? ((kp.key_row == 4'b1101) ? 4'b1100 : 4'hF)
                            : ((press_en && kp.key_row == row_sel) ? press_col : 4'hF);

  int         vectors     = 0;
  int         misses      = 0;
  int         valid_count = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;
  logic [3:0] row_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every key_valid cycle consumes one expected code.
  always @(negedge clk) begin
    if (rst && kp.key_valid === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        check("valid_with_empty_queue", exp_q.size(), 1);
      end else begin
        exp_code = exp_q.pop_front();
        check("key_code_at_valid", kp.key_code, exp_code);
        check("held_at_valid", kp.key_held, 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int i = 0;
    while (valid_count < target && i < budget) begin
      step(1);
      i++;
    end
    check("valid_seen", valid_count, target);
  endtask

  task automatic wait_held(input logic lvl, input int budget);
    int i = 0;
    while (kp.key_held !== lvl && i < budget) begin
      step(1);
      i++;
    end
    check("key_held_level", kp.key_held, lvl);
  endtask

  task automatic wait_row(input logic [3:0] pat, input logic want_eq, input int budget);
    int i = 0;
    while (((kp.key_row == pat) != want_eq) && i < budget) begin
      step(1);
      i++;
    end
    check("row_reached", (kp.key_row == pat), want_eq);
  endtask

  initial begin
    // Reset state.
    #1 rst = 1'b0;
    step(3);
    check("rst_key_row", kp.key_row, 4'b1110);
    check("rst_key_valid", kp.key_valid, 0);
    check("rst_key_code", kp.key_code, 0);
    check("rst_key_held", kp.key_held, 0);

    // Row stepping every FC clocks after reset release.
    rst = 1'b1;
    step(3);
    check("row0_hold", kp.key_row, 4'b1110);
    step(1);
    check("row1", kp.key_row, 4'b1101);
    step(4);
    check("row2", kp.key_row, 4'b1011);
    step(4);
    check("row3", kp.key_row, 4'b0111);
    step(4);
    check("row_wrap", kp.key_row, 4'b1110);

    // Key 0x9: row 2, column 1.
    exp_q.push_back(4'h9);
    press_row = 2'd2;
    press_col = 4'b1101;
    press_en  = 1'b1;
    wait_valid(1, 60);
    check("k9_code", kp.key_code, 4'h9);
    check("k9_held", kp.key_held, 1);
    step(40);
    check("k9_single_pulse", valid_count, 1);

    // Two-sample release glitch returns to PRESSED without a new pulse.
    press_en = 1'b0;
    step(8);
    press_en = 1'b1;
    step(40);
    check("glitch_no_valid", valid_count, 1);
    check("glitch_held", kp.key_held, 1);

    // Full release.
    press_en = 1'b0;
    wait_held(1'b0, 60);
    check("code_holds", kp.key_code, 4'h9);
    row_snap = kp.key_row;
    step(5);
    check("scan_resumes", (kp.key_row != row_snap), 1);

    // Bounce on key 0x3 (row 0, column 3): low, high, low, high, then stable.
    press_row = 2'd0;
    press_col = 4'b0111;
    for (int b = 0; b < 2; b++) begin
      wait_row(4'b1110, 1'b1, 40);
      press_en = 1'b1;
      step(6);
      press_en = 1'b0;
      wait_row(4'b1110, 1'b0, 20);
    end
    check("bounce_no_valid", valid_count, 1);
    exp_q.push_back(4'h3);
    press_en = 1'b1;
    wait_valid(2, 80);
    check("k3_code", kp.key_code, 4'h3);
    press_en = 1'b0;
    wait_held(1'b0, 60);

    // Ghost: two columns low on row 1.
    ghost = 1'b1;
    step(60);
    check("ghost_no_valid", valid_count, 2);
    row_snap = kp.key_row;
    step(5);
    check("ghost_scanning", (kp.key_row != row_snap), 1);
    ghost = 1'b0;

    // Reset during DEB_PRESS on key 0xC (row 3, column 0).
    press_row = 2'd3;
    press_col = 4'b1110;
    press_en  = 1'b1;
    wait_row(4'b0111, 1'b1, 40);
    step(10);
    check("deb_row_frozen", kp.key_row, 4'b0111);
    rst = 1'b0;
    #1;
    check("midrst_key_row", kp.key_row, 4'b1110);
    check("midrst_valid", kp.key_valid, 0);
    check("midrst_held", kp.key_held, 0);
    press_en = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);
    check("restart_row0", kp.key_row, 4'b1110);
    step(1);
    check("restart_row1", kp.key_row, 4'b1101);
    step(40);
    check("midrst_no_valid", valid_count, 2);

    // Key 0xF held: auto-repeat or single pulse depending on build.
    exp_q.push_back(4'hF);
    press_row = 2'd3;
    press_col = 4'b0111;
    press_en  = 1'b1;
    wait_valid(3, 80);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back(4'hF);
    step(30);
    check("repeat_not_early", valid_count, 3);
    step(1);
    check("repeat_at_32", kp.key_valid, 1);
    step(2);
    check("repeat_count", valid_count, 4);
`else
    step(80);
    check("no_repeat", valid_count, 3);
`endif
    press_en = 1'b0;
    wait_held(1'b0, 60);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
